bcd_display_scan: RTL

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed seven-segment scanner for a 0..299 BCD value.
// Shadowed digit data, optional leading-zero blanking, registered outputs.
module bcd_display_scan #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] dig_en,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_UNITS,
    S_TENS,
    S_HUND
  } state_t;

  localparam logic [15:0] TC_VAL = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  DASH   = 7'h40;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        tc;
  logic [3:0]  su;
  logic [3:0]  st;
  logic [1:0]  sh;
  logic [6:0]  seg_nxt;
  logic [2:0]  dig_nxt;
  logic        blank_h;
  logic        blank_t;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = DASH;
    endcase
    return s;
  endfunction

  assign tc = (cnt == TC_VAL);

  always_comb begin
    state_nxt = state;
    if (tc) begin
      unique case (state)
        S_UNITS: state_nxt = S_TENS;
        S_TENS:  state_nxt = S_HUND;
        S_HUND:  state_nxt = S_UNITS;
        default: state_nxt = S_UNITS;
      endcase
    end
  end

  // Tens blanks only when hundreds is also blank, so "007" shows as "  7".
  assign blank_h = blank_lz && (sh == 2'd0);
  assign blank_t = blank_h && (st == 4'd0);

  always_comb begin
    seg_nxt = 7'h00;
    dig_nxt = 3'b000;
    unique case (state)
      S_UNITS: begin
        seg_nxt = enc(su);
        dig_nxt = 3'b001;
      end
      S_TENS: begin
        if (!blank_t) begin
          seg_nxt = enc(st);
          dig_nxt = 3'b010;
        end
      end
      S_HUND: begin
        if (!blank_h) begin
          seg_nxt = (sh == 2'd3) ? DASH : enc({2'b00, sh});
          dig_nxt = 3'b100;
        end
      end
      default: begin
        seg_nxt = 7'h00;
        dig_nxt = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      state      <= S_UNITS;
      su         <= '0;
      st         <= '0;
      sh         <= '0;
      seg        <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tc ? '0 : cnt + 16'd1;
      state      <= state_nxt;
      seg        <= seg_nxt;
      dig_en     <= dig_nxt;
      frame_done <= tc && (state == S_HUND);
      if (load) begin
        su <= units;
        st <= tens;
        sh <= hundreds;
      end
    end
  end

endmodule
